xeng_acc_sched: RTL and testbench
=================================

# xeng_acc_sched

Integration scheduler for the X-engine cmac chain. It arms on a host command and aligns to the upstream sync. It then drives the `sync` input shared by all cmac instances, so that every 2^SERIAL_ACC_LEN_BITS-cycle serial accumulation window starts on a known cycle. After each window it sequences readout of the N_TAPS accumulator results off the cmac shift chain, and it flags sync misalignment.

## Interface
Parameters:
- SERIAL_ACC_LEN_BITS, 7, log2 of serial window length; must match the cmac parameter
- N_TAPS, 8, number of cmac stages in the chain; 1 ≤ N_TAPS ≤ 2^SERIAL_ACC_LEN_BITS
- RD_OFFSET, 4, cycles from window_end to first rd_valid; ≥1; covers multiplier, add and mux latency
- WIN_CNT_BITS, 16, width of the completed-window counter

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, asynchronous, active-high
- arm  in  1  single-cycle host pulse; arm scheduler
- stop  in  1  single-cycle host pulse; stop after current window
- sync_in  in  1  upstream sync pulse
- clear_err  in  1  clears resync_err
- cmac_sync  out  1  one-cycle pulse to cmac `sync`
- window_end  out  1  high on last cycle of each window
- win_count  out  WIN_CNT_BITS  completed windows since start; wraps
- rd_valid  out  1  readout strobe for chain output
- rd_tap  out  clog2(N_TAPS) (min 1)  tap index of current readout word, 0 first
- running  out  1  high in RUN and DRAIN
- resync_err  out  1  sticky misaligned-sync flag

## Operation
- FSM states: IDLE, ARMED, RUN, DRAIN. Reset → IDLE.
- IDLE: arm → ARMED. All other inputs ignored.
- ARMED:
  - sync_in → RUN, and cmac_sync pulses next cycle.
  - stop → IDLE.
  - If both are high in the same cycle, stop wins.
- RUN:
  - win_ctr (SERIAL_ACC_LEN_BITS bits) is 0 in the cmac_sync cycle, increments every cycle and wraps.
  - window_end = (win_ctr == all-ones) while in RUN/DRAIN.
  - On each window_end, win_count increments (wraps to 0).
  - arm is ignored.
- Sync checking in RUN:
  - sync_in when win_ctr == all-ones is aligned: ignored, no cmac_sync.
  - sync_in at any other count:
    - resync_err is set.
    - cmac_sync pulses next cycle.
    - win_ctr restarts at 0 in that cycle.
    - Any in-progress readout is aborted: rd_valid low from the next cycle.
    - A pending delayed window_end is cancelled.
  - win_count is not incremented for the truncated window.
- stop in RUN → DRAIN. DRAIN behaves as RUN, except that on window_end the FSM goes to IDLE. stop in DRAIN is ignored.
- Readout:
  - Each window_end launches a readout RD_OFFSET cycles later: rd_valid is high for N_TAPS consecutive cycles, with rd_tap = 0..N_TAPS-1.
  - Readout is independent of FSM state, so the final window's readout completes after IDLE is reached.
  - N_TAPS ≤ window length guarantees no readout overlap.
- clear_err clears resync_err. If clear_err and a new misalignment occur in the same cycle, set wins.
- rst mid-operation: all state returns to reset values immediately; an in-flight readout is dropped.

## Timing
- Reset values: cmac_sync=0, window_end=0, win_count=0, rd_valid=0, rd_tap=0, running=0, resync_err=0.
- All outputs are registered.
- cmac_sync: 1 cycle after the sampled sync_in.
- running: high from the cmac_sync cycle until the cycle after the final window_end.
- window_end: cycle C+2^S-1, where C is the cmac_sync cycle.
- rd_valid: first asserts at window_end cycle + RD_OFFSET; rd_tap=0 on that cycle.
- win_count: updates the cycle after window_end.
- resync_err: rises together with the corrective cmac_sync.

## Structure
- Shared package xeng_pkg holds:
  - FSM state enum (IDLE/ARMED/RUN/DRAIN)
  - clog2 helper for rd_tap width
  - default SERIAL_ACC_LEN_BITS shared with cmac
- Sub-module xeng_rd_seq:
  - RD_OFFSET delay line (existing `delay` block, ALLOW_SRL="YES", with a flush for abort)
  - tap counter generating rd_valid/rd_tap
- FSM, win_ctr and error logic live in the top.

## Test plan
(S=3 for short sims, N_TAPS=4, RD_OFFSET=4.)
- Reset mid-readout → all outputs 0 on the next edge; FSM IDLE.
- arm, then sync_in at cycle 10:
  - cmac_sync at 11
  - window_end at 18, 26
  - rd_valid 22–25 with rd_tap 0,1,2,3
  - win_count 1 at 19
- Aligned sync_in on a window_end cycle → no cmac_sync, resync_err stays 0.
- Misaligned sync_in at win_ctr=3 during readout:
  - cmac_sync and resync_err next cycle
  - rd_valid drops
  - next window_end 7 cycles after the new cmac_sync
- stop mid-window:
  - DRAIN until window_end, then IDLE and running=0
  - that window's full 4-word readout still occurs
  - later sync_in ignored
- clear_err and a misaligned sync_in in the same cycle → resync_err remains 1. Also: stop and sync_in together in ARMED → IDLE, no cmac_sync.

Source files
------------

// File: rtl/xeng_pkg.sv
// Shared X-engine definitions: scheduler FSM states, tap-index width helper,
// and the serial accumulation window length that the cmac chain also uses.
// Combinational content only, so it has no latency and no backpressure.
package xeng_pkg;

    // log2 of the cmac serial accumulation window; the cmac instances and the
    // scheduler must agree on this value.
    localparam int XENG_SERIAL_ACC_LEN_BITS = 7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } xeng_state_e;

    // ceil(log2(n)), but never less than 1, so that a single-tap chain still
    // gets a 1-bit index port.
    function automatic int xeng_clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/delay.sv
// Single-bit pulse delay line with flush.
// Latency: dout follows din by exactly DEPTH cycles.
// No backpressure; flush discards every pulse accepted up to and including the flush cycle.
//
// Ports: clk, rst (async, active-high), flush (synchronous discard),
//        din (pulse in), dout (pulse out, DEPTH cycles later).
module delay #(
    parameter int DEPTH     = 1,
    parameter     ALLOW_SRL = "YES"
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    input  logic din,
    output logic dout
);

    generate
        if (ALLOW_SRL == "YES") begin : g_srl
            // The shift data carries no reset or clear so it can map onto
            // shift-register primitives. Stale contents (after rst or flush)
            // are hidden by a small guard counter instead: once DEPTH edges
            // have passed, every bit in the chain was shifted in afterwards.
            localparam int GW = $clog2(DEPTH + 1);

            logic [DEPTH-1:0] sr;
            logic [GW-1:0]    guard;

            always_ff @(posedge clk) begin
                sr <= (sr << 1) | DEPTH'(din);
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    guard <= '0;
                end else if (flush) begin
                    guard <= '0;
                end else if (guard != GW'(DEPTH)) begin
                    guard <= guard + GW'(1);
                end
            end

            assign dout = sr[DEPTH-1] & (guard == GW'(DEPTH));
        end else begin : g_ff
            logic [DEPTH-1:0] sr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sr <= '0;
                end else if (flush) begin
                    sr <= '0;
                end else begin
                    sr <= (sr << 1) | DEPTH'(din);
                end
            end

            assign dout = sr[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/xeng_rd_seq.sv
// Readout sequencer: turns each window end into N_TAPS rd_valid strobes with a tap index.
// Latency: first rd_valid RD_OFFSET cycles after the registered window_end (win_end_nxt + RD_OFFSET + 1).
// No backpressure; abort drops both the pending start and any readout in progress.
//
// Ports: clk, rst (async, active-high), win_end_nxt (window_end one cycle
//        early), abort (misaligned resync), rd_valid, rd_tap (0 first).
module xeng_rd_seq import xeng_pkg::*; #(
    parameter int N_TAPS    = 8,
    parameter int RD_OFFSET = 4,
    parameter int TAP_W     = xeng_clog2(N_TAPS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             win_end_nxt,
    input  logic             abort,
    output logic             rd_valid,
    output logic [TAP_W-1:0] rd_tap
);

    logic start;

    // The input is the pre-register window_end, so RD_OFFSET stages plus the
    // rd_valid register land the first strobe RD_OFFSET cycles after the
    // registered window_end.
    delay #(
        .DEPTH     (RD_OFFSET),
        .ALLOW_SRL ("YES")
    ) u_start_dly (
        .clk   (clk),
        .rst   (rst),
        .flush (abort),
        .din   (win_end_nxt),
        .dout  (start)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_tap   <= '0;
        end else if (abort) begin
            rd_valid <= 1'b0;
            rd_tap   <= '0;
        end else if (start) begin
            rd_valid <= 1'b1;
            rd_tap   <= '0;
        end else if (rd_valid) begin
            if (rd_tap == TAP_W'(N_TAPS - 1)) begin
                rd_valid <= 1'b0;
                rd_tap   <= '0;
            end else begin
                rd_tap <= rd_tap + TAP_W'(1);
            end
        end
    end

endmodule

// File: rtl/xeng_acc_sched.sv
// X-engine accumulation scheduler: arms on host command, aligns to sync_in, drives cmac sync, sequences readout.
// Latency: cmac_sync 1 cycle after sync_in; window_end at cmac_sync + 2^S - 1; rd_valid RD_OFFSET after window_end.
// No backpressure: host pulses and sync_in are sampled every cycle, outputs are free-running strobes.
//
// Ports: clk, rst (async, active-high); arm, stop, sync_in, clear_err in;
//        cmac_sync, window_end, win_count, rd_valid, rd_tap, running,
//        resync_err out (all registered).
module xeng_acc_sched import xeng_pkg::*; #(
    parameter  int SERIAL_ACC_LEN_BITS = XENG_SERIAL_ACC_LEN_BITS,
    parameter  int N_TAPS              = 8,
    parameter  int RD_OFFSET           = 4,
    parameter  int WIN_CNT_BITS        = 16,
    localparam int TAP_W               = xeng_clog2(N_TAPS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    arm,
    input  logic                    stop,
    input  logic                    sync_in,
    input  logic                    clear_err,
    output logic                    cmac_sync,
    output logic                    window_end,
    output logic [WIN_CNT_BITS-1:0] win_count,
    output logic                    rd_valid,
    output logic [TAP_W-1:0]        rd_tap,
    output logic                    running,
    output logic                    resync_err
);

    localparam logic [SERIAL_ACC_LEN_BITS-1:0] CTR_LAST = '1;

    xeng_state_e                    state_q, state_d;
    logic [SERIAL_ACC_LEN_BITS-1:0] win_ctr_q, win_ctr_d;
    logic                           sync_fire;
    logic                           misalign;
    logic                           running_d;
    logic                           window_end_d;
    logic                           resync_err_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            win_ctr_q  <= '0;
            cmac_sync  <= 1'b0;
            window_end <= 1'b0;
            win_count  <= '0;
            running    <= 1'b0;
            resync_err <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_ctr_q  <= win_ctr_d;
            cmac_sync  <= sync_fire;
            window_end <= window_end_d;
            running    <= running_d;
            resync_err <= resync_err_d;
            if (window_end) begin
                win_count <= win_count + WIN_CNT_BITS'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        win_ctr_d = win_ctr_q;
        sync_fire = 1'b0;
        misalign  = 1'b0;

        case (state_q)
            IDLE: begin
                if (arm) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (sync_in) begin
                    state_d   = RUN;
                    sync_fire = 1'b1;
                    win_ctr_d = '0;
                end
            end
            RUN, DRAIN: begin
                win_ctr_d = win_ctr_q + SERIAL_ACC_LEN_BITS'(1);
                // window_end is high exactly when win_ctr is all-ones in
                // RUN/DRAIN, so it doubles as the "sync is aligned" test.
                if (sync_in && !window_end) begin
                    misalign  = 1'b1;
                    sync_fire = 1'b1;
                    win_ctr_d = '0;
                end
                if (state_q == RUN && stop) begin
                    state_d = DRAIN;
                end else if (state_q == DRAIN && window_end) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        running_d    = (state_d == RUN) || (state_d == DRAIN);
        window_end_d = running_d && (win_ctr_d == CTR_LAST);

        // A new misalignment beats a simultaneous clear.
        if (misalign) begin
            resync_err_d = 1'b1;
        end else if (clear_err) begin
            resync_err_d = 1'b0;
        end else begin
            resync_err_d = resync_err;
        end
    end

    xeng_rd_seq #(
        .N_TAPS    (N_TAPS),
        .RD_OFFSET (RD_OFFSET),
        .TAP_W     (TAP_W)
    ) u_rd_seq (
        .clk         (clk),
        .rst         (rst),
        .win_end_nxt (window_end_d),
        .abort       (misalign),
        .rd_valid    (rd_valid),
        .rd_tap      (rd_tap)
    );

endmodule

// File: tb/tb_xeng_acc_sched.sv
// Directed bench for xeng_acc_sched with S=3 (8-cycle windows), N_TAPS=4, RD_OFFSET=4.
// Cycle n is the period after the n-th rising edge following reset release;
// inputs driven in cycle n are sampled at its closing edge.
// Expected output timelines below are hand-derived from the cycle schedule.
module tb_xeng_acc_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, stop, sync_in, clear_err;
    logic        cmac_sync, window_end, rd_valid, running, resync_err;
    logic [15:0] win_count;
    logic [1:0]  rd_tap;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    xeng_acc_sched #(
        .SERIAL_ACC_LEN_BITS (3),
        .N_TAPS              (4),
        .RD_OFFSET           (4),
        .WIN_CNT_BITS        (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .stop       (stop),
        .sync_in    (sync_in),
        .clear_err  (clear_err),
        .cmac_sync  (cmac_sync),
        .window_end (window_end),
        .win_count  (win_count),
        .rd_valid   (rd_valid),
        .rd_tap     (rd_tap),
        .running    (running),
        .resync_err (resync_err)
    );

    task automatic chk(input string tag, input int n, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag, input int n);
        chk({tag, "_cmac_sync"},  n, 32'(cmac_sync),  32'd0);
        chk({tag, "_window_end"}, n, 32'(window_end), 32'd0);
        chk({tag, "_win_count"},  n, 32'(win_count),  32'd0);
        chk({tag, "_rd_valid"},   n, 32'(rd_valid),   32'd0);
        chk({tag, "_rd_tap"},     n, 32'(rd_tap),     32'd0);
        chk({tag, "_running"},    n, 32'(running),    32'd0);
        chk({tag, "_resync_err"}, n, 32'(resync_err), 32'd0);
    endtask

    initial begin
        logic        e_sync, e_we, e_rv, e_run, e_err;
        logic [31:0] e_tap, e_cnt;

        rst       = 1'b1;
        arm       = 1'b0;
        stop      = 1'b0;
        sync_in   = 1'b0;
        clear_err = 1'b0;
        tick();
        tick();
        chk_all_zero("reset", -1);
        rst = 1'b0;

        // Timeline:
        //  arm 5, sync 10 -> cmac_sync 11, windows end 18,26,34, readouts 22,30,38
        //  sync 34 is aligned (window_end) -> ignored
        //  sync 38 at win_ctr=3 mid-readout -> resync at 39, readout cut after tap 0
        //  window_end 46; sync+clear_err 48 (win_ctr=1) -> resync at 49, err stays,
        //    pending readout for cycle 50 cancelled
        //  clear_err 50 -> err 0 from 51; stop 52 -> DRAIN; window_end 56 -> IDLE,
        //    running 0 at 57, readout 60..63 still happens; sync 58 ignored
        //  arm 66, stop+sync 69 -> IDLE, no cmac_sync; sync 72 ignored
        //  arm 75, sync 78 -> cmac_sync 79, window_end 86, readout from 90
        for (int n = 0; n <= 92; n++) begin
            e_sync = (n inside {11, 39, 49, 79});
            e_we   = (n inside {18, 26, 34, 46, 56, 86});
            e_run  = (n inside {[11:56], [79:92]});
            e_err  = (n inside {[39:50]});
            e_rv   = 1'b1;
            if (n inside {[22:25]})      e_tap = 32'(n - 22);
            else if (n inside {[30:33]}) e_tap = 32'(n - 30);
            else if (n == 38)            e_tap = 32'd0;
            else if (n inside {[60:63]}) e_tap = 32'(n - 60);
            else if (n inside {[90:92]}) e_tap = 32'(n - 90);
            else begin
                e_rv  = 1'b0;
                e_tap = 32'd0;
            end
            if (n >= 57)      e_cnt = 32'd5;
            else if (n >= 47) e_cnt = 32'd4;
            else if (n >= 35) e_cnt = 32'd3;
            else if (n >= 27) e_cnt = 32'd2;
            else if (n >= 19) e_cnt = 32'd1;
            else              e_cnt = 32'd0;

            chk("cmac_sync",  n, 32'(cmac_sync),  32'(e_sync));
            chk("window_end", n, 32'(window_end), 32'(e_we));
            chk("rd_valid",   n, 32'(rd_valid),   32'(e_rv));
            chk("rd_tap",     n, 32'(rd_tap),     e_tap);
            chk("running",    n, 32'(running),    32'(e_run));
            chk("resync_err", n, 32'(resync_err), 32'(e_err));
            if (n <= 78) begin
                chk("win_count", n, 32'(win_count), e_cnt);
            end

            arm       = (n inside {5, 66, 75});
            sync_in   = (n inside {10, 34, 38, 48, 58, 69, 72, 78});
            clear_err = (n inside {48, 50});
            stop      = (n inside {52, 69});
            if (n < 92) begin
                tick();
            end
        end

        // Cycle 92 is mid-readout (tap 2). Reset now; the remaining word must
        // never appear and the FSM must be back in IDLE.
        rst = 1'b1;
        tick();
        chk_all_zero("rst_mid", 93);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk("post_rst_rd_valid",  94 + k, 32'(rd_valid),  32'd0);
            chk("post_rst_cmac_sync", 94 + k, 32'(cmac_sync), 32'd0);
            chk("post_rst_running",   94 + k, 32'(running),   32'd0);
            sync_in = (k == 2);
            tick();
        end
        sync_in = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
